// File: rtl/muldiv_seq.sv
// Sequential 32-bit multiply/divide unit with HI/LO result registers.
// One radix-2 step per cycle: 32 RUN cycles, then a FIX cycle for sign correction and write-back.
module muldiv_seq (
  input  logic        clock,
  input  logic        nreset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic        divzero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic        is_div;
  logic        neg_lo;   // product sign (mult) or quotient sign (div)
  logic        neg_hi;   // remainder sign, follows the dividend
  logic        dz_pend;
  logic [31:0] opnd;     // multiplicand or divisor magnitude
  logic [63:0] acc;      // mult: {partial product, multiplier}; div: {remainder, quotient}

  logic        signed_op, a_neg, b_neg;
  logic [31:0] a_abs, b_abs;
  logic [32:0] msum;
  logic [63:0] mult_nxt;
  logic [32:0] dshift;
  logic [33:0] ddiff;
  logic [63:0] div_nxt;
  logic [31:0] fix_hi, fix_lo;

  assign signed_op = ~op[0];
  assign a_neg     = signed_op & a[31];
  assign b_neg     = signed_op & b[31];
  assign a_abs     = a_neg ? (32'd0 - a) : a;
  assign b_abs     = b_neg ? (32'd0 - b) : b;

  // Shift-add: add the multiplicand into the upper half when the multiplier LSB is set.
  assign msum     = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
  assign mult_nxt = {msum, acc[31:1]};

  // Restoring division: a 34-bit difference exposes the borrow in bit 33.
  assign dshift  = {acc[63:32], acc[31]};
  assign ddiff   = {1'b0, dshift} - {2'b00, opnd};
  assign div_nxt = ddiff[33] ? {dshift[31:0], acc[30:0], 1'b0}
                             : {ddiff[31:0],  acc[30:0], 1'b1};

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    fix_hi = acc[63:32];
    fix_lo = acc[31:0];
    if (!is_div) begin
      if (neg_lo) {fix_hi, fix_lo} = 64'd0 - acc;
    end else begin
      if (neg_lo) fix_lo = 32'd0 - acc[31:0];
      if (neg_hi) fix_hi = 32'd0 - acc[63:32];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state_nxt = S_RUN;
        S_RUN:   if (cnt == 5'd31) state_nxt = S_FIX;
        S_FIX:   state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state != S_IDLE);
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_lo  <= 1'b0;
      neg_hi  <= 1'b0;
      dz_pend <= 1'b0;
      opnd    <= '0;
      acc     <= '0;
      done    <= 1'b0;
      divzero <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done    <= 1'b0;
      divzero <= 1'b0;
      if (flush) begin
        cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              is_div  <= op[1];
              opnd    <= op[1] ? b_abs : a_abs;
              acc     <= op[1] ? {32'd0, a_abs} : {32'd0, b_abs};
              neg_lo  <= a_neg ^ b_neg;
              neg_hi  <= a_neg;
              dz_pend <= op[1] && (b == 32'd0);
              cnt     <= '0;
            end else begin
              if (mthi) hi <= a;
              if (mtlo) lo <= a;
            end
          end
          S_RUN: begin
            acc <= is_div ? div_nxt : mult_nxt;
            cnt <= (cnt == 5'd31) ? 5'd0 : cnt + 5'd1;
          end
          S_FIX: begin
            done    <= 1'b1;
            divzero <= dz_pend;
            if (!dz_pend) begin
              hi <= fix_hi;
              lo <= fix_lo;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: stimulus queues expected results, a negedge monitor
// pops and compares them when Done is due.
module tb_muldiv_seq;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic        clock, nreset, start, mthi, mtlo, flush;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, divzero;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          due;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   k;
  logic [31:0] m_hi, m_lo;

  muldiv_seq dut (
    .clock   (clock),
    .nreset  (nreset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .divzero (divzero),
    .hi      (hi),
    .lo      (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clock);
  endtask

  // Called at a negedge; the operation is accepted on the following rising edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                       input bit push, output int acc_edge);
    exp_t e;
    op = o; a = va; b = vb; start = 1'b1;
    acc_edge = cyc + 1;
    if (push) begin
      e.hi = ehi; e.lo = elo; e.dz = edz; e.due = cyc + 34;
      sb.push_back(e);
    end
    @(negedge clock);
    start = 1'b0;
  endtask

  always @(negedge clock) begin
    if (nreset === 1'b1) begin
      if (!done) check("divzero_without_done", {63'd0, divzero}, 64'd0);
      if (sb.size() > 0 && cyc >= sb[0].due) begin
        mon_e = sb.pop_front();
        check("done_pulse", {63'd0, done}, 64'd1);
        check("hi_result", {32'd0, hi}, {32'd0, mon_e.hi});
        check("lo_result", {32'd0, lo}, {32'd0, mon_e.lo});
        check("divzero_flag", {63'd0, divzero}, {63'd0, mon_e.dz});
      end else if (done) begin
        check("unexpected_done", {63'd0, done}, 64'd0);
      end
    end
  end

  initial begin
    start = 0; mthi = 0; mtlo = 0; flush = 0; op = 0; a = 0; b = 0;
    nreset = 1'b1;
    #3 nreset = 1'b0;
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_divzero", {63'd0, divzero}, 64'd0);
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    repeat (2) @(negedge clock);
    nreset = 1'b1;
    check("idle_busy", {63'd0, busy}, 64'd0);

    // First Start right after reset release; Busy window k+1..k+33 checked explicitly.
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 1'b1, k);
    check("busy_first_cycle", {63'd0, busy}, 64'd1);
    wait_cyc(k + 32);
    check("busy_fix_cycle", {63'd0, busy}, 64'd1);
    wait_cyc(k + 33);
    check("busy_done_cycle", {63'd0, busy}, 64'd0);

    // Back-to-back Start in the Done cycle, plus an ignored Start while busy.
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b1, k);
    wait_cyc(k + 4);
    op = OP_DIVU; a = 32'd1; b = 32'd0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_cyc(k + 33);

    // Register moves in IDLE.
    mthi = 1'b1; mtlo = 1'b1; a = 32'h1234_5678;
    @(negedge clock);
    mthi = 1'b0; mtlo = 1'b0;
    check("mthi_mtlo_hi", {32'd0, hi}, 64'h1234_5678);
    check("mthi_mtlo_lo", {32'd0, lo}, 64'h1234_5678);
    mtlo = 1'b1; a = 32'h0000_AAAA;
    @(negedge clock);
    mtlo = 1'b0;
    check("mtlo_only_lo", {32'd0, lo}, 64'h0000_AAAA);
    check("mtlo_only_hi", {32'd0, hi}, 64'h1234_5678);

    // Start with MTHI in the same cycle: Start wins; MTLO while busy is ignored.
    mthi = 1'b1;
    issue(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1, k);
    mthi = 1'b0;
    check("start_beats_mthi", {32'd0, hi}, 64'h1234_5678);
    wait_cyc(k + 3);
    mtlo = 1'b1; a = 32'hDEAD_BEEF;
    @(negedge clock);
    mtlo = 1'b0;
    check("mtlo_while_busy", {32'd0, lo}, 64'h0000_AAAA);
    wait_cyc(k + 33);

    // Directed arithmetic vectors, issued back to back.
    vecs.push_back('{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0});
    vecs.push_back('{OP_DIVU,  32'd7,         32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1});
    vecs.push_back('{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0});
    vecs.push_back('{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0});
    vecs.push_back('{OP_MULT,  32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 1'b0});
    vecs.push_back('{OP_DIVU,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0001, 1'b0});
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz, 1'b1, k);
      wait_cyc(k + 33);
    end
    m_hi = 32'h0000_0001; m_lo = 32'h0000_0001;

    // Flush in cycle k+10, restart at edge k+11, completion in cycle k+45.
    @(negedge clock);
    issue(OP_MULTU, 32'd5, 32'd6, 32'd0, 32'd0, 1'b0, 1'b0, k);
    wait_cyc(k + 9);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    check("flush_busy_low", {63'd0, busy}, 64'd0);
    check("flush_hi_kept", {32'd0, hi}, {32'd0, m_hi});
    check("flush_lo_kept", {32'd0, lo}, {32'd0, m_lo});
    issue(OP_MULTU, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, 1'b1, k);
    wait_cyc(k + 33);

    // Flush together with Start in IDLE: nothing accepted.
    @(negedge clock);
    flush = 1'b1; start = 1'b1; op = OP_MULTU; a = 32'd9; b = 32'd9;
    @(negedge clock);
    flush = 1'b0; start = 1'b0;
    check("flush_start_idle", {63'd0, busy}, 64'd0);
    repeat (40) @(negedge clock);
    check("flush_start_hi", {32'd0, hi}, 64'd0);
    check("flush_start_lo", {32'd0, lo}, 64'd30);

    // Reset pulse in cycle k+20 of a DIV discards it.
    issue(OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1, k);
    wait_cyc(k + 19);
    sb.delete();
    nreset = 1'b0;
    #1;
    check("midrun_rst_hi", {32'd0, hi}, 64'd0);
    check("midrun_rst_lo", {32'd0, lo}, 64'd0);
    check("midrun_rst_busy", {63'd0, busy}, 64'd0);
    check("midrun_rst_done", {63'd0, done}, 64'd0);
    @(negedge clock);
    nreset = 1'b1;
    repeat (40) @(negedge clock);
    check("post_rst_busy", {63'd0, busy}, 64'd0);
    check("post_rst_lo", {32'd0, lo}, 64'd0);

    for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clock);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
